carregador_programa: RTL and testbench

- Program loader that sits directly upstream of the 8-bit processor's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes the program into instruction memory.
- Validates the stream with an 8-bit checksum and holds the processor in reset until a valid program is loaded.
- Replaces direct memory initialisation from the bench; the processor top instantiates it alongside the instruction memory.

---
 rtl/carregador_programa.sv | 160 ++++++++++++++++
 tb/tb_carregador_programa.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// carregador_programa: program loader in front of the instruction memory.
// Accepts a framed byte stream (length, N program bytes, checksum) over a
// valid/ready handshake. It writes the program bytes into instruction memory
// and keeps the processor in reset until the checksum of a complete frame
// matches.
//
// Optional build macro: CARREGADOR_ZERA_EN. When defined, reset and iniciar
// first sweep the whole memory to zero (state LIMPA) before accepting a frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   stream byte present on in_data
//   in_data    stream byte
//   in_ready   loader can accept a byte this cycle
//   iniciar    one-cycle pulse; restarts loading from PRONTO or ERRO
//   mem_we     instruction-memory write enable (one pulse per byte)
//   mem_addr   instruction-memory write address
//   mem_data   instruction-memory write data
//   cpu_reset  high while the processor must stay in reset
//   done       program loaded and checksum OK
//   erro       checksum mismatch
//   palavras   program bytes written in the current load
module carregador_programa #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  iniciar,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  erro,
  output logic [ADDR_WIDTH:0]   palavras
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ESPERA_TAM,
    CARREGA,
    CHECA,
    PRONTO,
    ERRO
`ifdef CARREGADOR_ZERA_EN
    , LIMPA
`endif
  } state_t;

`ifdef CARREGADOR_ZERA_EN
  localparam state_t INICIO = LIMPA;
  localparam logic   READY_INICIO = 1'b0;
`else
  localparam state_t INICIO = ESPERA_TAM;
  localparam logic   READY_INICIO = 1'b1;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      restante_q;
  logic [DATA_WIDTH-1:0] soma_q;
  logic                  xfer_c;
  logic                  ready_d, cpu_reset_d, done_d, erro_d;
`ifdef CARREGADOR_ZERA_EN
  logic [CNT_W-1:0]      limpa_q;
`endif

  assign xfer_c = in_valid & in_ready;

  // Next-state logic and registered-output decodes of the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ESPERA_TAM: if (xfer_c) state_d = CARREGA;
      CARREGA:    if (xfer_c && restante_q == CNT_W'(1)) state_d = CHECA;
      CHECA:      if (xfer_c) state_d = (in_data == soma_q) ? PRONTO : ERRO;
      PRONTO:     if (iniciar) state_d = INICIO;
      ERRO:       if (iniciar) state_d = INICIO;
`ifdef CARREGADOR_ZERA_EN
      // One extra cycle after the last write so in_ready never overlaps a sweep pulse.
      LIMPA:      if (limpa_q == DEPTH) state_d = ESPERA_TAM;
`endif
      default:    state_d = INICIO;
    endcase

    ready_d     = (state_d == ESPERA_TAM) || (state_d == CARREGA) || (state_d == CHECA);
    cpu_reset_d = (state_d != PRONTO);
    done_d      = (state_d == PRONTO);
    erro_d      = (state_d == ERRO);
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INICIO;
      in_ready   <= READY_INICIO;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      erro       <= 1'b0;
      palavras   <= '0;
      restante_q <= '0;
      soma_q     <= '0;
`ifdef CARREGADOR_ZERA_EN
      limpa_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      in_ready  <= ready_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      erro      <= erro_d;
      mem_we    <= 1'b0;

      unique case (state_q)
        ESPERA_TAM: begin
          if (xfer_c) begin
            // Length 0 stands for a full memory image.
            restante_q <= (in_data == '0) ? DEPTH : CNT_W'(in_data);
            palavras   <= '0;
            soma_q     <= '0;
          end
        end
        CARREGA: begin
          if (xfer_c) begin
            mem_we     <= 1'b1;
            mem_addr   <= palavras[ADDR_WIDTH-1:0];
            mem_data   <= in_data;
            soma_q     <= soma_q + in_data;
            palavras   <= palavras + CNT_W'(1);
            restante_q <= restante_q - CNT_W'(1);
          end
        end
`ifdef CARREGADOR_ZERA_EN
        PRONTO, ERRO: begin
          if (iniciar) limpa_q <= '0;
        end
        LIMPA: begin
          if (limpa_q != DEPTH) begin
            mem_we   <= 1'b1;
            mem_addr <= limpa_q[ADDR_WIDTH-1:0];
            mem_data <= '0;
            limpa_q  <= limpa_q + CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: a table of short frames, hand
// sequences for the long/stalled/reset corner cases, and random frames checked
// against a frame-level model (expected writes and verdict from the bytes).
module tb_carregador_programa;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
`ifdef CARREGADOR_ZERA_EN
  localparam bit ZERA = 1'b1;
`else
  localparam bit ZERA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, iniciar;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, cpu_reset, done, erro;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW:0]   palavras;

  carregador_programa #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .iniciar(iniciar), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_reset(cpu_reset),
    .done(done), .erro(erro), .palavras(palavras)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  int            ready_during_we = 0;
  logic [DW-1:0] fdata[$];

  // Record every write pulse seen on the memory port.
  always @(posedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      wq.push_back('{cyc, mem_addr, mem_data});
      if (in_ready) ready_during_we++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after 'gap' idle cycles and return just after its transfer edge.
  task automatic put_byte(input logic [DW-1:0] b, input int gap, input bit rnd_ini);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      iniciar  = rnd_ini && ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    iniciar  = 1'b0;
    for (int w = 0; w < 3000 && !in_ready; w++) tick();
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
    end else begin
      iniciar = rnd_ini && ($urandom_range(0, 3) == 0);
      tick();
    end
  endtask

  // Sends length, fdata and checksum; checks verdict and writes against the frame.
  task automatic run_frame(input logic [DW-1:0] len_b, input logic [DW-1:0] chk_b,
                           input int gmin, input int gmax, input bit rnd_ini);
    int            n;
    logic [DW-1:0] sum;
    bit            ok;
    n   = (len_b == '0) ? (1 << AW) : int'(len_b);
    sum = '0;
    foreach (fdata[i]) sum = sum + fdata[i];
    ok = (sum == chk_b);

    put_byte(len_b, int'($urandom_range(gmax, gmin)), rnd_ini);
    wq.delete();
    for (int i = 0; i < n; i++) put_byte(fdata[i], int'($urandom_range(gmax, gmin)), rnd_ini);
    put_byte(chk_b, int'($urandom_range(gmax, gmin)), rnd_ini);
    in_valid = 1'b0;
    iniciar  = 1'b0;

    check("done", 32'(done), 32'(ok));
    check("erro", 32'(erro), 32'(!ok));
    check("cpu_reset", 32'(cpu_reset), 32'(!ok));
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("palavras", 32'(palavras), 32'(n));
    check("no_we_checksum", 32'(mem_we), 32'd0);
    check("n_writes", 32'(wq.size()), 32'(n));
    for (int i = 0; i < wq.size() && i < n; i++) begin
      check("wr_addr", 32'(wq[i].a), 32'(i));
      check("wr_data", 32'(wq[i].d), 32'(fdata[i]));
    end
    if (gmax == 0 && wq.size() == n)
      check("back_to_back", 32'(wq[n-1].cyc - wq[0].cyc), 32'(n - 1));
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("ini_in_ready", 32'(in_ready), 32'(!ZERA));
    check("ini_erro", 32'(erro), 32'd0);
    check("ini_done", 32'(done), 32'd0);
    check("ini_cpu_reset", 32'(cpu_reset), 32'd1);
  endtask

  typedef struct {
    logic [DW-1:0] len;
    logic [DW-1:0] d0, d1, d2;
    logic [DW-1:0] chk;
    bit            exp_done;
    logic [AW:0]   exp_pal;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs = '{
      '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16, 1'b1, 9'd3},
      '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h17, 1'b0, 9'd3},
      '{8'h01, 8'h55, 8'h00, 8'h00, 8'h55, 1'b1, 9'd1},
      '{8'h02, 8'h10, 8'h20, 8'h00, 8'h30, 1'b1, 9'd2},
      '{8'h02, 8'hFF, 8'h02, 8'h00, 8'h01, 1'b1, 9'd2},
      '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 9'd1},
      '{8'h01, 8'h80, 8'h00, 8'h00, 8'h81, 1'b0, 9'd1}
    };

    reset = 1'b1; in_valid = 1'b0; in_data = '0; iniciar = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'(!ZERA));
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_palavras", 32'(palavras), 32'd0);
    reset = 1'b0;

`ifdef CARREGADOR_ZERA_EN
    // Zero sweep after reset: full address range, in_ready low throughout.
    wq.delete();
    ready_during_we = 0;
    for (int w = 0; w < 1000 && !in_ready; w++) tick();
    check("sweep_done", 32'(in_ready), 32'd1);
    check("sweep_count", 32'(wq.size()), 32'(1 << AW));
    for (int i = 0; i < wq.size(); i++) begin
      check("sweep_addr", 32'(wq[i].a), 32'(i));
      check("sweep_data", 32'(wq[i].d), 32'd0);
    end
    check("sweep_ready_low", 32'(ready_during_we), 32'd0);
`endif

    // Table of short frames, stream held valid.
    for (int v = 0; v < 7; v++) begin
      fdata.delete();
      if (vecs[v].len >= 1) fdata.push_back(vecs[v].d0);
      if (vecs[v].len >= 2) fdata.push_back(vecs[v].d1);
      if (vecs[v].len >= 3) fdata.push_back(vecs[v].d2);
      run_frame(vecs[v].len, vecs[v].chk, 0, 0, 1'b0);
      check("tbl_done", 32'(done), 32'(vecs[v].exp_done));
      check("tbl_palavras", 32'(palavras), 32'(vecs[v].exp_pal));
      pulse_iniciar();
    end

    // Length 0 means a full 256-byte image.
    fdata.delete();
    for (int i = 0; i < 256; i++) fdata.push_back(8'h01);
    run_frame(8'h00, 8'h00, 0, 0, 1'b0);
    pulse_iniciar();

    // Stalled stream: one idle cycle before every byte.
    fdata.delete();
    fdata.push_back(8'h10);
    fdata.push_back(8'h20);
    run_frame(8'h02, 8'h30, 1, 1, 1'b0);
    if (wq.size() == 2) check("stall_spacing", 32'(wq[1].cyc - wq[0].cyc), 32'd2);
    pulse_iniciar();

    // Reset after 2 of 4 data bytes, with a byte offered during reset.
    put_byte(8'h04, 0, 1'b0);
    put_byte(8'h11, 0, 1'b0);
    put_byte(8'h22, 0, 1'b0);
    check("mid_we_before", 32'(mem_we), 32'd1);
    in_data = 8'h33;
    reset   = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'(!ZERA));
    check("mid_palavras", 32'(palavras), 32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("mid_we_after", 32'(mem_we), 32'd0);
    fdata.delete();
    fdata.push_back(8'h55);
    run_frame(8'h01, 8'h55, 0, 0, 1'b0);
    pulse_iniciar();

    // Random frames with random stalls and ignored iniciar pulses.
    for (int f = 0; f < 25; f++) begin
      int            n;
      logic [DW-1:0] s;
      n = int'($urandom_range(1, 12));
      fdata.delete();
      s = '0;
      for (int i = 0; i < n; i++) begin
        fdata.push_back(DW'($urandom));
        s = s + fdata[i];
      end
      if ($urandom_range(0, 3) == 0) s = s + DW'($urandom_range(1, 255));
      run_frame(DW'(n), s, 0, 2, 1'b1);
      pulse_iniciar();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
